// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths, instruction field positions and forward-select encoding
package operand_fetch_pkg;
    localparam int XLEN_DEF = 32;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    typedef enum logic [1:0] {FWD_RF, FWD_WB, FWD_MEM, FWD_EX} fwd_e;
endpackage

// File: rtl/operand_fetch_reg_file.sv
// reg_file: 2-read/1-write register file, asynchronous read, x0 never written so it reads 0
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: forwarding mux, load-use stall FSM and single-entry operand buffer
// Define WB_BYPASS_EN to forward same-cycle writebacks instead of stalling one cycle on them.
module operand_fetch import operand_fetch_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    input  logic [31:0]     dec_inst,
    output logic            dec_ready,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_val,
    input  logic            mem_valid,
    input  logic            mem_is_load,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_val,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_val,
    input  logic            flush,
    output logic            op_valid,
    output logic [31:0]     op_inst,
    output logic [XLEN-1:0] op_rs1,
    output logic [XLEN-1:0] op_rs2,
    input  logic            op_ready
);
`ifdef WB_BYPASS_EN
    localparam logic WB_FWD = 1'b1;
`else
    localparam logic WB_FWD = 1'b0;
`endif
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0]      state;
    logic [1:0]      cnt;
    logic [AW-1:0]   rs [2];
    logic [XLEN-1:0] rf_rd [2];
    logic [XLEN-1:0] opnd [2];
    logic [1:0]      need [2];
    fwd_e            sel [2];
    logic [1:0]      need_max;
    logic            hazard;
    logic            accept;

    assign rs[0] = dec_inst[RS1_LSB +: AW];
    assign rs[1] = dec_inst[RS2_LSB +: AW];

    reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk(clk), .rst(rst), .we(wb_we), .wa(wb_rd), .wd(wb_val),
        .ra1(rs[0]), .ra2(rs[1]), .rd1(rf_rd[0]), .rd2(rf_rd[1])
    );

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic nz;
        assign nz = rs[s] != '0;
        assign sel[s] = (nz && ex_valid && ex_rd == rs[s]) ? FWD_EX :
                        (nz && mem_valid && mem_rd == rs[s]) ? FWD_MEM :
                        (nz && wb_we && wb_rd == rs[s]) ? FWD_WB : FWD_RF;
        // Loads have no data yet; without bypass a WB hit waits for the regfile write.
        assign need[s] = (sel[s] == FWD_EX && ex_is_load) ? 2'd2 :
                         (sel[s] == FWD_MEM && mem_is_load) ? 2'd1 :
                         (sel[s] == FWD_WB && !WB_FWD) ? 2'd1 : 2'd0;
        assign opnd[s] = sel[s] == FWD_EX ? ex_val :
                         sel[s] == FWD_MEM ? mem_val :
                         sel[s] == FWD_WB ? wb_val : rf_rd[s];
    end

    always_comb begin
        need_max = need[0] > need[1] ? need[0] : need[1];
        hazard = state == IDLE && dec_valid && need_max != 2'd0;
        dec_ready = state == IDLE && !hazard && (!op_valid || op_ready);
        accept = dec_valid && dec_ready;
    end

    // The detection cycle is the first stall cycle, so cnt holds the remaining ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 2'd0;
            op_valid <= 1'b0;
            op_inst <= '0;
            op_rs1 <= '0;
            op_rs2 <= '0;
        end else begin
            if (flush) begin
                state <= IDLE;
                cnt <= 2'd0;
            end else if (state == STALL) begin
                cnt <= cnt - 2'd1;
                state <= cnt == 2'd1 ? IDLE : STALL;
            end else if (hazard) begin
                cnt <= need_max - 2'd1;
                state <= need_max > 2'd1 ? STALL : IDLE;
            end
            if (flush) begin
                op_valid <= 1'b0;
            end else if (accept) begin
                op_valid <= 1'b1;
                op_inst <= dec_inst;
                op_rs1 <= opnd[0];
                op_rs2 <= opnd[1];
            end else if (op_ready) begin
                op_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, 32, operand/data width in bits.
REQ-002 Parameter NREG, 32, architectural register count (power of two); AW = clog2(NREG).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 dec_valid  in  1  decode offers an instruction this cycle.
REQ-006 dec_inst  in  32  instruction; rs1 = inst[19:15], rs2 = inst[24:20] (low AW bits used).
REQ-007 dec_ready  out  1  fetch accepts dec_inst this cycle.
REQ-008 ex_valid, ex_is_load  in  1 each  EX stage holds an instruction that writes rd / that is a load.
REQ-009 ex_rd  in  AW  EX destination; ex_val  in  XLEN  EX ALU result.
REQ-010 mem_valid, mem_is_load  in  1 each; mem_rd  in  AW; mem_val  in  XLEN  MEM-stage equivalents.
REQ-011 wb_we  in  1; wb_rd  in  AW; wb_val  in  XLEN  writeback port into the register file.
REQ-012 flush  in  1  squash the held operand bundle and any pending stall.
REQ-013 op_valid  out  1; op_inst  out  32; op_rs1, op_rs2  out  XLEN each  registered operand bundle to execute.
REQ-014 op_ready  in  1  execute consumes the bundle when op_valid && op_ready.

Function
REQ-015 Register file SHALL be 2-read/1-write, asynchronous read, synchronous write on wb_we with wb_rd != 0.
REQ-016 Register 0 SHALL read as 0 and SHALL never be a forwarding match.
REQ-017 Operand select per source, priority EX > MEM > WB > regfile; a source matches when its valid/we is high and its rd equals rs.
REQ-018 EX match with ex_is_load SHALL NOT forward; it SHALL raise a load-use stall of 2 cycles.
REQ-019 MEM match with mem_is_load SHALL NOT forward; it SHALL raise a load-use stall of 1 cycle.
REQ-020 Stall FSM states IDLE and STALL with 2-bit down-counter; IDLE->STALL on detected hazard with counter loaded (larger requirement across rs1/rs2); STALL->IDLE when counter reaches 1 and decrements.
REQ-021 While in STALL, or on the cycle a hazard is detected, dec_ready SHALL be 0 and no bundle SHALL be loaded.
REQ-022 Outside stall, dec_ready = !op_valid || op_ready (skid-free single-entry buffer).
REQ-023 On dec_valid && dec_ready, op_* SHALL load next edge: latency exactly 1 cycle from acceptance to op_valid.
REQ-024 op_valid && !op_ready SHALL hold op_* unchanged (no operand re-evaluation).
REQ-025 Consume and new accept in the same cycle SHALL replace the bundle with no bubble.
REQ-026 flush SHALL clear op_valid and return FSM to IDLE next edge, overriding any accept that cycle; register-file writes are unaffected.

Reset
REQ-027 On rst: op_valid=0, op_inst=0, op_rs1=0, op_rs2=0, FSM=IDLE, counter=0, all registers cleared to 0.
REQ-028 rst mid-stall SHALL abandon the stall; dec_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-029 Macro WB_BYPASS_EN defined: a same-cycle wb_we write to rs SHALL be forwarded (write-through) at priority below MEM.
REQ-030 Macro WB_BYPASS_EN undefined: no WB forwarding; a wb_rd match with wb_we SHALL add a 1-cycle stall (regfile read returns the new value next cycle).

Structure
REQ-031 Shared package SHALL hold XLEN default, the rs1/rs2 bit-field positions, and the forward-select enum (FWD_RF, FWD_WB, FWD_MEM, FWD_EX).
REQ-032 Register file SHALL be a separate sub-module, reg_file, parametrised by XLEN and NREG; forwarding mux, FSM and output buffer stay in operand_fetch.

Verification
REQ-033 x5=0x11 via WB; then accept inst rs1=5, rs2=0 -> next cycle op_valid=1, op_rs1=0x11, op_rs2=0.
REQ-034 ex_valid, ex_rd=5, ex_val=0xAA and mem_rd=5, mem_val=0xBB both valid; accept rs1=5 -> op_rs1=0xAA.
REQ-035 ex_is_load, ex_rd=7; dec rs2=7 -> dec_ready=0 for 2 cycles, accepted cycle 3 with MEM/WB value.
REQ-036 op_valid=1, op_ready=0 for 3 cycles while ex_val changes -> op_rs1 stable; op_ready=1 with dec_valid -> new bundle next cycle, no bubble.
REQ-037 Stall in progress, assert flush then rst -> op_valid=0, FSM IDLE, dec_ready=1 after rst release.
REQ-038 wb_we, wb_rd=3, wb_val=0x5 with dec rs1=3 -> with WB_BYPASS_EN op_rs1=0x5 in 1 cycle; without it 1-cycle stall then op_rs1=0x5.
